// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with fetch timeout and sticky HALT.
// Latency: 4 cycles/instruction minimum; strobes Moore except ir_load/rf_wr_en. Backpressure: imem_ack wait, stall hold.
module mips_multicycle_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_imem_ack,
   input  logic             i_dec_writeenable,
   input  logic             i_dec_except,
   input  logic             i_stall,
   output logic             o_imem_req,
   output logic             o_ir_load,
   output logic             o_alu_en,
   output logic             o_rf_wr_en,
   output logic             o_pc_en,
   output logic [2:0]       o_state,
   output logic             o_halted,
   output logic [1:0]       o_exc_cause,
   output logic [CNT_W-1:0] o_retired
);

   localparam int WC_W = $clog2(TIMEOUT);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      WRITEBACK = 3'd3,
      HALT      = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WC_W-1:0]   r_wait_cnt;
   logic [WC_W-1:0]   w_wait_nxt;
   logic [1:0]        r_exc_cause;
   logic [1:0]        w_cause_nxt;
   logic [CNT_W-1:0]  r_retired;
   logic              w_retire;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= FETCH;
         r_wait_cnt  <= '0;
         r_exc_cause <= 2'd0;
         r_retired   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait_cnt  <= w_wait_nxt;
         r_exc_cause <= w_cause_nxt;
         if (w_retire)
            r_retired <= r_retired + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = HALT;
      w_wait_nxt  = r_wait_cnt;
      w_cause_nxt = r_exc_cause;
      w_retire    = 1'b0;
      o_imem_req  = 1'b0;
      o_ir_load   = 1'b0;
      o_alu_en    = 1'b0;
      o_rf_wr_en  = 1'b0;
      o_pc_en     = 1'b0;
      o_halted    = 1'b0;
      case (r_state)
         FETCH: begin
            o_imem_req = 1'b1;
            o_ir_load  = i_imem_ack;
            // ack on the last permitted cycle still beats the timeout
            if (i_imem_ack) begin
               w_state_nxt = DECODE;
               w_wait_nxt  = '0;
            end else if (r_wait_cnt == WC_LAST) begin
               w_state_nxt = HALT;
               w_cause_nxt = 2'd2;
            end else begin
               w_state_nxt = FETCH;
               w_wait_nxt  = r_wait_cnt + WC_W'(1);
            end
         end
         DECODE: begin
            if (i_dec_except) begin
               w_state_nxt = HALT;
               w_cause_nxt = 2'd1;
            end else begin
               w_state_nxt = EXECUTE;
            end
         end
         EXECUTE: begin
            o_alu_en    = 1'b1;
            w_state_nxt = i_stall ? EXECUTE : WRITEBACK;
         end
         WRITEBACK: begin
            o_rf_wr_en  = i_dec_writeenable;
            o_pc_en     = 1'b1;
            w_retire    = 1'b1;
            w_wait_nxt  = '0;
            w_state_nxt = FETCH;
         end
         default: begin
            o_halted    = 1'b1;
            w_state_nxt = HALT;
         end
      endcase
   end

   assign o_state     = r_state;
   assign o_exc_cause = r_exc_cause;
   assign o_retired   = r_retired;

endmodule
